// File: rtl/enc4to2_rr.sv
// Registered 4-to-2 request encoder with valid/ack handshake.
// RR=1 selects round-robin arbitration, RR=0 fixed priority (W[3] highest).
module enc4to2_rr #(
   parameter bit RR = 1'b1
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       En,
   input  logic [3:0] W,
   input  logic       Ack,
   output logic [1:0] Y,
   output logic       z,
   output logic [0:3] G
);

   localparam logic IDLE  = 1'b0;
   localparam logic GRANT = 1'b1;

   logic       s;
   logic [1:0] p;
   logic [1:0] y_inc;
   logic       req;

   // Lowest scan offset from the pointer wins in RR mode.
   function automatic logic [1:0] sel(input logic [3:0] w,
                                      input logic [1:0] ptr);
      logic [1:0] r;
      logic [1:0] idx;
      r = 2'd0;
      if (RR) begin
         for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (w[idx]) r = idx;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w[i]) r = 2'(i);
         end
      end
      return r;
   endfunction

   assign y_inc = Y + 2'd1;
   assign req   = En && (W != 4'b0000);
   assign z     = s;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         s <= IDLE;
         Y <= 2'd0;
         p <= 2'd0;
      end else begin
         unique case (s)
            IDLE: begin
               if (req) begin
                  Y <= sel(W, p);
                  s <= GRANT;
               end
            end
            GRANT: begin
               if (Ack) begin
                  p <= y_inc;
                  if (req) Y <= sel(W, y_inc);
                  else     s <= IDLE;
               end
            end
            default: s <= IDLE;
         endcase
      end
   end

   always_comb begin
      G = 4'b0000;
      if (z) G[Y] = 1'b1;
   end

endmodule

// File: tb/tb_enc4to2_rr.sv
// Randomized and directed bench for enc4to2_rr, both arbitration modes
// driven from shared inputs and compared against a behavioural model.
module tb_enc4to2_rr;

   logic       Clock;
   logic       Reset;
   logic       En;
   logic [3:0] W;
   logic       Ack;
   logic [1:0] y0, y1;
   logic       z0, z1;
   logic [0:3] g0, g1;

   int n_cmp;
   int n_bad;

   // Model state: index 0 = fixed priority, index 1 = round-robin.
   int mv[2];
   int my[2];
   int mp[2];

   enc4to2_rr #(.RR(1'b0)) dut0 (
      .Clock(Clock), .Reset(Reset), .En(En), .W(W), .Ack(Ack),
      .Y(y0), .z(z0), .G(g0)
   );

   enc4to2_rr #(.RR(1'b1)) dut1 (
      .Clock(Clock), .Reset(Reset), .En(En), .W(W), .Ack(Ack),
      .Y(y1), .z(z1), .G(g1)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int msel(input int rr, input logic [3:0] w,
                               input int ptr);
      if (rr != 0) begin
         for (int k = 0; k < 4; k++)
            if (w[(ptr + k) % 4]) return (ptr + k) % 4;
      end else begin
         for (int i = 3; i >= 0; i--)
            if (w[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         if (Reset) begin
            mv[m] = 0; my[m] = 0; mp[m] = 0;
         end else if (mv[m] == 0) begin
            if (En && W != 0) begin
               my[m] = msel(m, W, mp[m]);
               mv[m] = 1;
            end
         end else if (Ack) begin
            mp[m] = (my[m] + 1) % 4;
            if (En && W != 0) my[m] = msel(m, W, mp[m]);
            else mv[m] = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [3:0] w,
                       input logic a);
      logic [0:3] ge;
      Reset = r; En = e; W = w; Ack = a;
      @(posedge Clock);
      model_edge();
      #1;
      check("z0", 32'(z0), 32'(mv[0]));
      check("z1", 32'(z1), 32'(mv[1]));
      check("y0", 32'(y0), 32'(my[0]));
      check("y1", 32'(y1), 32'(my[1]));
      ge = 4'b0000;
      if (mv[0] != 0) ge[my[0]] = 1'b1;
      check("g0", 32'(g0), 32'(ge));
      ge = 4'b0000;
      if (mv[1] != 0) ge[my[1]] = 1'b1;
      check("g1", 32'(g1), 32'(ge));
   endtask

   int rr_seq[4] = '{1, 2, 3, 0};
   int alt_seq[3] = '{1, 3, 1};

   initial begin
      n_cmp = 0; n_bad = 0;
      for (int m = 0; m < 2; m++) begin
         mv[m] = 0; my[m] = 0; mp[m] = 0;
      end
      Reset = 1'b1; En = 1'b1; W = 4'hF; Ack = 1'b1;

      repeat (2) begin
         step(1'b1, 1'b1, 4'hF, 1'b1);
         check("rst_z", 32'(z1), 32'd0);
         check("rst_y", 32'(y1), 32'd0);
         check("rst_g", 32'(g1), 32'd0);
      end

      step(1'b0, 1'b1, 4'hF, 1'b0);
      check("first_y1", 32'(y1), 32'd0);
      check("first_z1", 32'(z1), 32'd1);
      check("first_y0", 32'(y0), 32'd3);

      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 4'hF, 1'b1);
         check("rr_seq", 32'(y1), 32'(rr_seq[i]));
         check("rr_z", 32'(z1), 32'd1);
      end

      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 4'b1010, 1'b1);
         check("rr_1010", 32'(y1), 32'(alt_seq[i]));
      end

      step(1'b0, 1'b0, 4'h0, 1'b1);
      check("ack_noen_z", 32'(z1), 32'd0);
      check("ack_noen_y", 32'(y1), 32'd1);
      repeat (2) begin
         step(1'b0, 1'b0, 4'hF, 1'b0);
         check("noen_z", 32'(z1), 32'd0);
      end

      step(1'b0, 1'b0, 4'h0, 1'b1);
      step(1'b0, 1'b1, 4'hF, 1'b0);
      check("idle_ack_p", 32'(y1), 32'd2);

      step(1'b1, 1'b1, 4'hF, 1'b1);
      check("rst_ack_z", 32'(z1), 32'd0);
      check("rst_ack_y", 32'(y1), 32'd0);
      step(1'b0, 1'b1, 4'hF, 1'b0);
      check("rst_p", 32'(y1), 32'd0);

      step(1'b0, 1'b0, 4'h0, 1'b1);
      step(1'b0, 1'b1, 4'b0100, 1'b0);
      check("single_y", 32'(y1), 32'd2);
      check("single_g", 32'(g1), 32'b0010);
      step(1'b0, 1'b1, 4'h0, 1'b1);
      check("single_z", 32'(z1), 32'd0);
      check("single_hold", 32'(y1), 32'd2);

      step(1'b0, 1'b1, 4'b0110, 1'b0);
      check("fp_y", 32'(y0), 32'd2);
      check("fp_g", 32'(g0), 32'b0010);
      step(1'b0, 1'b1, 4'b0001, 1'b0);
      check("fp_hold", 32'(y0), 32'd2);
      step(1'b0, 1'b1, 4'b0001, 1'b1);
      check("fp_next", 32'(y0), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 3) != 0),
              4'($urandom),
              ($urandom_range(0, 1) == 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
